// File: rtl/vnu_pkg.sv
// Shared types and helpers for the variable-node frame sequencer:
// FSM state encoding, accumulator sizing and sign-magnitude conversion.
package vnu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } vnu_state_t;

  // Signed accumulator width holding (deg+1) full-scale messages.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned deg);
    return dw + $clog2(deg + 1);
  endfunction

  // Message index width for a given column weight.
  function automatic int unsigned idx_width(input int unsigned deg);
    return (deg > 1) ? $clog2(deg) : 1;
  endfunction

  // Largest magnitude representable in a dw-bit sign-magnitude word.
  function automatic int sat_max(input int unsigned dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // Sign-magnitude to two's complement; negative zero maps to 0.
  function automatic int tc_ext(input logic [31:0] sm, input int unsigned dw);
    int mag;
    mag = int'(sm) & sat_max(dw);
    return sm[dw - 1] ? -mag : mag;
  endfunction

  // Symmetric clamp to +/-(2^(dw-1)-1).
  function automatic int sat_sym(input int v, input int unsigned dw);
    if (v > sat_max(dw)) return sat_max(dw);
    if (v < -sat_max(dw)) return -sat_max(dw);
    return v;
  endfunction

  // Two's complement to sign-magnitude; zero is always positive zero.
  function automatic logic [31:0] sm_from_tc(input int v, input int unsigned dw);
    if (v < 0) return (32'd1 << (dw - 1)) | 32'(-v);
    return 32'(v);
  endfunction

endpackage

// File: rtl/vnu_msg_buffer.sv
// Per-frame store of the incoming check messages (two's complement),
// one write port and one combinational read index, cleared on reset.
module vnu_msg_buffer #(
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Register file write with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Combinational read of the selected entry.
  always_comb begin
    rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/vnu_frame_sequencer.sv
// Variable-node update sequencer: takes one channel LLR and DEGREE check
// messages per frame, then emits DEGREE extrinsic messages plus a hard
// decision. Optional macro VNU_SAT_CNT_EN adds a saturation event counter.
module vnu_frame_sequencer
  import vnu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned DEGREE     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  llr_valid,
  output logic                  llr_ready,
  input  logic [DATA_WIDTH-1:0] llr_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
`ifdef VNU_SAT_CNT_EN
  output logic [15:0]           sat_count,
`endif
  output logic                  hard_dec
);

  localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, DEGREE);
  localparam int unsigned IDX_WIDTH = idx_width(DEGREE);

  vnu_state_t state, state_next;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] llr_tc;
  logic signed [ACC_WIDTH-1:0] in_tc;
  logic signed [ACC_WIDTH-1:0] buf_rd;
  logic signed [31:0]          diff;
  logic [IDX_WIDTH-1:0]        idx;
  logic                        live;
  logic                        last_idx;
  logic                        llr_fire;
  logic                        in_fire;
  logic                        out_fire;

  assign llr_tc   = ACC_WIDTH'(tc_ext(32'(llr_data), DATA_WIDTH));
  assign in_tc    = ACC_WIDTH'(tc_ext(32'(in_data), DATA_WIDTH));
  assign diff     = 32'(acc) - 32'(buf_rd);
  assign last_idx = (idx == IDX_WIDTH'(DEGREE - 1));
  assign llr_fire = llr_valid && llr_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  vnu_msg_buffer #(
    .DEPTH     (DEGREE),
    .WIDTH     (ACC_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_msg_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_fire),
    .wr_idx  (idx),
    .wr_data (in_tc),
    .rd_idx  (idx),
    .rd_data (buf_rd)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (llr_fire)             state_next = ACCUM;
      ACCUM:   if (in_fire && last_idx)  state_next = EMIT;
      EMIT:    if (out_fire && last_idx) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from registered state, accumulator and buffer only.
  always_comb begin
    llr_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    hard_dec  = 1'b0;
    unique case (state)
      IDLE:  llr_ready = live;
      ACCUM: in_ready  = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        out_data  = DATA_WIDTH'(sm_from_tc(sat_sym(diff, DATA_WIDTH), DATA_WIDTH));
        out_last  = last_idx;
        hard_dec  = acc[ACC_WIDTH-1];
      end
      default: ;
    endcase
  end

  // Accumulator, message index and post-reset ready qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      idx  <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      if (llr_fire) begin
        acc <= llr_tc;
        idx <= '0;
      end else if (in_fire) begin
        acc <= acc + in_tc;
        idx <= last_idx ? '0 : idx + 1'b1;
      end else if (out_fire) begin
        idx <= last_idx ? '0 : idx + 1'b1;
      end
    end
  end

`ifdef VNU_SAT_CNT_EN
  // Count accepted extrinsics that needed clamping; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (out_fire && (sat_sym(diff, DATA_WIDTH) != diff) && (sat_count != '1)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule
